sr_cmd_driver: RTL and testbench

SR_CMD_DRIVER -- requirements
Module: sr_cmd_driver

---
 rtl/sr_cmd_driver.sv | 133 +++++++++++++
 tb/tb_sr_cmd_driver.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_driver.sv
// sr_cmd_driver -- drives set/reset pulses into an external SR latch and
// confirms the latch followed the command.
//
// Parameters:
//   PULSE_W  set/reset pulse width in clk cycles (1..15)
//   TIMEOUT  maximum WAIT cycles allowed for confirmation (4..255)
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_op  command offer; cmd_op 1 = set, 0 = reset
//   cmd_ready         high while idle and able to accept a command
//   s, r              registered set/reset drives to the latch (never both 1)
//   q, q_not          latch outputs, asynchronous to clk (synchronized here)
//   done              one-cycle completion pulse
//   err, err_code     result: 00 ok, 01 timeout, 10 invalid (q == q_not)
//   state_q           last latch state confirmed by the block
//   busy              high whenever the FSM is not IDLE
module sr_cmd_driver #(
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic       cmd_op,
  output logic       cmd_ready,
  output logic       s,
  output logic       r,
  input  logic       q,
  input  logic       q_not,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       state_q,
  output logic       busy
);

  localparam int unsigned PW = $clog2(PULSE_W) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PULSE_W);
  localparam logic [TW-1:0] WCNT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT, RESP} state_t;

  state_t        state;
  logic          op_r;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] wcnt;
  logic          q_m, q_s, qn_m, qn_s;

  // Two-flop synchronizers for the asynchronous latch outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_m  <= 1'b0;
      q_s  <= 1'b0;
      qn_m <= 1'b0;
      qn_s <= 1'b0;
    end else begin
      q_m  <= q;
      q_s  <= q_m;
      qn_m <= q_not;
      qn_s <= qn_m;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      s         <= 1'b0;
      r         <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
      state_q   <= 1'b0;
      op_r      <= 1'b0;
      pcnt      <= '0;
      wcnt      <= '0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= '0;
      case (state)
        IDLE: begin
          // cmd_ready is registered, so it rises one edge after reset
          // release and after RESP, and drops at the accept edge.
          if (cmd_valid && cmd_ready) begin
            op_r      <= cmd_op;
            s         <= cmd_op;
            r         <= ~cmd_op;
            pcnt      <= PW'(1);
            cmd_ready <= 1'b0;
            state     <= PULSE;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        PULSE: begin
          // The accept edge counts as the first pulse cycle.
          if (pcnt == PCNT_LAST) begin
            s     <= 1'b0;
            r     <= 1'b0;
            wcnt  <= '0;
            state <= WAIT;
          end else begin
            pcnt <= pcnt + PW'(1);
          end
        end
        WAIT: begin
          if (q_s == op_r && qn_s == ~op_r) begin
            done    <= 1'b1;
            state_q <= op_r;
            state   <= RESP;
          end else if (wcnt == WCNT_LAST) begin
            done     <= 1'b1;
            err      <= 1'b1;
            err_code <= (q_s == qn_s) ? 2'b10 : 2'b01;
            state    <= RESP;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        end
        RESP: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_cmd_driver.sv
module tb_sr_cmd_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_op = 1'b0;
  logic       cmd_ready, s, r, done, err, state_q, busy;
  logic [1:0] err_code;
  logic       q, q_not;

  // Behavioural latch state, and bench overrides used to hold q/q_not.
  logic lq = 1'b0, lqn = 1'b1;
  logic hold = 1'b0, f_q = 1'b0, f_qn = 1'b1;
  logic overlap = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign q     = hold ? f_q  : lq;
  assign q_not = hold ? f_qn : lqn;

  // NOR-style SR latch with 1 ns response.
  always begin
    @(s or r);
    #1;
    if (s) begin
      lqn = 1'b0;
      lq  = 1'b1;
    end else if (r) begin
      lq  = 1'b0;
      lqn = 1'b1;
    end
  end

  always @(negedge clk) if (s && r) overlap = 1'b1;

  sr_cmd_driver #(.PULSE_W(2), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .s(s), .r(r), .q(q), .q_not(q_not),
    .done(done), .err(err), .err_code(err_code), .state_q(state_q),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full ok command with an ideal latch: accept E0, pulse E0..E2, done at E3.
  task automatic ok_cmd(input logic op);
    logic nop;
    nop = ~op;
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    chk("e0_s", s, op);
    chk("e0_r", r, nop);
    chk("e0_busy", busy, 1);
    chk("e0_ready", cmd_ready, 0);
    cmd_valid = 1'b0;
    tick();
    chk("e1_s", s, op);
    chk("e1_r", r, nop);
    tick();
    chk("e2_s", s, 0);
    chk("e2_r", r, 0);
    chk("e2_done", done, 0);
    tick();
    chk("e3_done", done, 1);
    chk("e3_err", err, 0);
    chk("e3_code", err_code, 0);
    chk("e3_state_q", state_q, op);
    tick();
    chk("e4_done", done, 0);
    chk("e4_ready", cmd_ready, 1);
    chk("e4_busy", busy, 0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_s", s, 0);
    chk("rst_r", r, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state_q", state_q, 0);
    chk("rst_ready", cmd_ready, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", cmd_ready, 1);

    // Set, then reset
    ok_cmd(1'b1);
    ok_cmd(1'b0);

    // Timeout: latch held at q=0/q_not=1, set command never confirms
    hold = 1'b1; f_q = 1'b0; f_qn = 1'b1;
    cmd_valid = 1'b1; cmd_op = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (16) tick();
    chk("to_e16_done", done, 0);
    chk("to_e16_busy", busy, 1);
    tick();
    chk("to_done", done, 1);
    chk("to_err", err, 1);
    chk("to_code", err_code, 2'b01);
    chk("to_state_q", state_q, 0);
    tick();
    chk("to_done_low", done, 0);
    chk("to_code_low", err_code, 0);

    // Invalid: q and q_not both 0
    f_q = 1'b0; f_qn = 1'b0;
    cmd_valid = 1'b1; cmd_op = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (16) tick();
    chk("inv_e16_done", done, 0);
    tick();
    chk("inv_done", done, 1);
    chk("inv_err", err, 1);
    chk("inv_code", err_code, 2'b10);
    chk("inv_state_q", state_q, 0);
    tick();
    hold = 1'b0;

    // Back-pressure: cmd_valid held high across a whole command
    cmd_valid = 1'b1; cmd_op = 1'b0;
    tick();
    chk("bp_e0_r", r, 1);
    chk("bp_e0_busy", busy, 1);
    tick();
    chk("bp_e1_ready", cmd_ready, 0);
    tick();
    chk("bp_e2_busy", busy, 1);
    tick();
    chk("bp_e3_done", done, 1);
    tick();
    chk("bp_e4_busy", busy, 0);
    chk("bp_e4_ready", cmd_ready, 1);
    chk("bp_e4_done", done, 0);
    tick();
    chk("bp_e5_busy", busy, 1);
    chk("bp_e5_r", r, 1);
    chk("bp_e5_ready", cmd_ready, 0);
    tick();
    chk("bp_e6_r", r, 1);

    // Abort in the second pulse cycle
    rst = 1'b1; cmd_valid = 1'b0;
    tick();
    chk("ab_s", s, 0);
    chk("ab_r", r, 0);
    chk("ab_busy", busy, 0);
    chk("ab_ready", cmd_ready, 0);
    chk("ab_done", done, 0);
    rst = 1'b0;
    tick();
    chk("ab_ready_next", cmd_ready, 1);
    chk("ab_done_next", done, 0);
    repeat (3) tick();
    chk("ab_no_done", done, 0);

    // Redundant set issued twice
    ok_cmd(1'b1);
    ok_cmd(1'b1);
    chk("redundant_state_q", state_q, 1);

    chk("s_and_r_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
